// File: rtl/alu4_logic_resp.sv
`default_nettype none
// ============================================================================
// Module   : alu4_logic_resp
// Purpose  : Bitwise logic unit (AND / OR / XOR / NAND) with a valid/ready
//            request port and a first-word-fall-through result FIFO on the
//            response side. Every accepted request produces one result,
//            visible one cycle after acceptance, in acceptance order.
// Ports    : clk, rst           - clock, synchronous active-high reset
//            req_valid/ready    - request handshake
//            req_a, req_b       - WIDTH-bit operands
//            req_op             - 00 AND, 01 OR, 10 XOR, 11 NAND
//            rsp_valid/ready    - response handshake (FIFO head)
//            rsp_data, rsp_op   - head result and the opcode that made it
//            rsp_zero           - head result is all zeros (only when valid)
//            level              - FIFO occupancy, 0..DEPTH
//            txn_count          - accepted requests, modulo 256
// Revision : 1.0 - initial release
// ============================================================================
module alu4_logic_resp #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [WIDTH-1:0]         req_a,
    input  logic [WIDTH-1:0]         req_b,
    input  logic [1:0]               req_op,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [WIDTH-1:0]         rsp_data,
    output logic [1:0]               rsp_op,
    output logic                     rsp_zero,
    output logic [$clog2(DEPTH):0]   level,
    output logic [7:0]               txn_count
);

    // DEPTH is a power of two, so pointers of c_PTR_W bits wrap naturally
    // modulo DEPTH; the level counter needs one extra bit to represent "full".
    localparam int                 c_PTR_W   = $clog2(DEPTH);
    localparam logic [c_PTR_W:0]   c_FULL    = (c_PTR_W + 1)'(DEPTH);
    localparam logic [c_PTR_W:0]   c_LVL_ONE = (c_PTR_W + 1)'(1);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);

    localparam logic [1:0] c_OP_AND  = 2'b00;
    localparam logic [1:0] c_OP_OR   = 2'b01;
    localparam logic [1:0] c_OP_XOR  = 2'b10;
    localparam logic [1:0] c_OP_NAND = 2'b11;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [WIDTH-1:0]   r_mem_data [DEPTH];
    logic [1:0]         r_mem_op   [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W:0]   r_level;
    logic [7:0]         r_txn_count;

    // ------------------------------------------------------------------------
    // Handshakes
    // ------------------------------------------------------------------------
    logic             w_push;
    logic             w_pop;
    logic             w_not_empty;
    logic [WIDTH-1:0] w_result;
    logic [WIDTH-1:0] w_head_data;

    assign w_not_empty = (r_level != '0);

    // Ready looks only at occupancy and reset: a pop on the same edge never
    // frees a slot for a request, so a full FIFO always costs the requester
    // one retry cycle. Gating with rst keeps a request from being "accepted"
    // on a reset edge.
    assign req_ready = ~rst & (r_level < c_FULL);
    assign w_push    = req_valid & req_ready;
    assign w_pop     = w_not_empty & rsp_ready;

    // ------------------------------------------------------------------------
    // Logic function - purely bitwise, no carries between bit positions
    // ------------------------------------------------------------------------
    always_comb begin
        w_result = '0;
        case (req_op)
            c_OP_AND:  w_result = req_a & req_b;
            c_OP_OR:   w_result = req_a | req_b;
            c_OP_XOR:  w_result = req_a ^ req_b;
            c_OP_NAND: w_result = ~(req_a & req_b);
            default:   w_result = '0;
        endcase
    end

    // ------------------------------------------------------------------------
    // Storage. Entries are not cleared on reset: resetting the pointers and
    // level already makes every stored entry unreachable.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_data[r_wr_ptr] <= w_result;
            r_mem_op[r_wr_ptr]   <= req_op;
        end
    end

    // ------------------------------------------------------------------------
    // Pointers, occupancy and transaction counter. Reset wins over any
    // concurrent push or pop.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_level     <= '0;
            r_txn_count <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr    <= r_wr_ptr + c_PTR_ONE;
                r_txn_count <= r_txn_count + 8'd1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + c_LVL_ONE;
                2'b01:   r_level <= r_level - c_LVL_ONE;
                default: r_level <= r_level;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Response side: head entry shown straight from registered state. A
    // result written on an edge only becomes visible after that edge, so
    // there is no same-cycle bypass from request to response. Outputs are
    // forced to zero when empty so stale entries never leak out.
    // ------------------------------------------------------------------------
    assign w_head_data = r_mem_data[r_rd_ptr];

    assign rsp_valid = w_not_empty;
    assign rsp_data  = w_not_empty ? w_head_data : '0;
    assign rsp_op    = w_not_empty ? r_mem_op[r_rd_ptr] : 2'b00;
    assign rsp_zero  = w_not_empty & (w_head_data == '0);
    assign level     = r_level;
    assign txn_count = r_txn_count;

endmodule
`default_nettype wire

// File: tb/tb_alu4_logic_resp.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu4_logic_resp
// Purpose  : Self-checking bench for alu4_logic_resp. A queue-based model of
//            the result FIFO predicts every output each cycle; directed
//            scenarios cover the reference sequences, followed by a
//            randomized run with occasional resets.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu4_logic_resp;

    localparam int W = 4;
    localparam int D = 4;

    logic         clk;
    logic         r_rst;
    logic         r_req_valid;
    logic         w_req_ready;
    logic [W-1:0] r_req_a;
    logic [W-1:0] r_req_b;
    logic [1:0]   r_req_op;
    logic         w_rsp_valid;
    logic         r_rsp_ready;
    logic [W-1:0] w_rsp_data;
    logic [1:0]   w_rsp_op;
    logic         w_rsp_zero;
    logic [2:0]   w_level;
    logic [7:0]   w_txn_count;

    alu4_logic_resp #(.WIDTH(W), .DEPTH(D)) u_dut (
        .clk       (clk),
        .rst       (r_rst),
        .req_valid (r_req_valid),
        .req_ready (w_req_ready),
        .req_a     (r_req_a),
        .req_b     (r_req_b),
        .req_op    (r_req_op),
        .rsp_valid (w_rsp_valid),
        .rsp_ready (r_rsp_ready),
        .rsp_data  (w_rsp_data),
        .rsp_op    (w_rsp_op),
        .rsp_zero  (w_rsp_zero),
        .level     (w_level),
        .txn_count (w_txn_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: queue of {op, result}, plus a transaction counter.
    logic [5:0] q_model [$];
    int         m_txn = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] ref_logic(input logic [W-1:0] a, input logic [W-1:0] b,
                                               input logic [1:0] op);
        case (op)
            2'b00:   return a & b;
            2'b01:   return a | b;
            2'b10:   return a ^ b;
            default: return ~(a & b);
        endcase
    endfunction

    // One clock cycle: drive on the falling edge, compare all outputs with
    // the model just before the rising edge, then advance the model.
    task automatic step(input bit rs, input bit v, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [1:0] op, input bit rr);
        bit         e_valid;
        bit         e_ready;
        bit         acc;
        bit         pop;
        logic [5:0] head;
        @(negedge clk);
        r_rst       = rs;
        r_req_valid = v;
        r_req_a     = a;
        r_req_b     = b;
        r_req_op    = op;
        r_rsp_ready = rr;
        #1;
        e_valid = (q_model.size() != 0);
        head    = e_valid ? q_model[0] : 6'd0;
        e_ready = !rs && (q_model.size() < D);
        chk("rsp_valid", 32'(w_rsp_valid), 32'(e_valid));
        chk("rsp_data",  32'(w_rsp_data),  32'(head[3:0]));
        chk("rsp_op",    32'(w_rsp_op),    32'(head[5:4]));
        chk("rsp_zero",  32'(w_rsp_zero),  32'(e_valid && head[3:0] == 4'd0));
        chk("level",     32'(w_level),     32'(q_model.size()));
        chk("req_ready", 32'(w_req_ready), 32'(e_ready));
        chk("txn_count", 32'(w_txn_count), 32'(m_txn));
        acc = v && e_ready;
        pop = e_valid && rr;
        @(posedge clk);
        if (rs) begin
            q_model.delete();
            m_txn = 0;
        end else begin
            if (pop) void'(q_model.pop_front());
            if (acc) begin
                q_model.push_back({op, ref_logic(a, b, op)});
                m_txn = (m_txn + 1) % 256;
            end
        end
    endtask

    task automatic idle(input bit rr);
        step(1'b0, 1'b0, 4'h0, 4'h0, 2'b00, rr);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 4'h0, 4'h0, 2'b00, 1'b0);
        step(1'b1, 1'b0, 4'h0, 4'h0, 2'b00, 1'b0);
    endtask

    initial begin
        r_rst = 1'b1; r_req_valid = 1'b0; r_req_a = '0; r_req_b = '0;
        r_req_op = 2'b00; r_rsp_ready = 1'b0;

        // Reset state
        do_reset();
        idle(1'b0);

        // Two ANDs, one of them zero; each result visible the cycle after accept
        step(1'b0, 1'b1, 4'b0000, 4'b1111, 2'b00, 1'b1);
        #2;
        chk("first_valid", 32'(w_rsp_valid), 32'd1);
        chk("first_zero",  32'(w_rsp_zero),  32'd1);
        step(1'b0, 1'b1, 4'b1110, 4'b0010, 2'b00, 1'b1);
        #2;
        chk("second_data", 32'(w_rsp_data), 32'b0010);
        chk("second_zero", 32'(w_rsp_zero), 32'd0);
        idle(1'b1);
        #2;
        chk("txn_two", 32'(w_txn_count), 32'd2);

        // OR / XOR / NAND back to back
        step(1'b0, 1'b1, 4'b1100, 4'b1010, 2'b01, 1'b0);
        step(1'b0, 1'b1, 4'b1100, 4'b1010, 2'b10, 1'b0);
        step(1'b0, 1'b1, 4'b1100, 4'b1010, 2'b11, 1'b0);
        #2;
        chk("or_head", 32'(w_rsp_data), 32'b1110);
        repeat (4) idle(1'b1);

        // Back-pressure: fill, hold the 5th, pulse rsp_ready
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 4'(i), 4'hF, 2'b01, 1'b0);
        #2;
        chk("full_level", 32'(w_level), 32'd4);
        chk("full_ready", 32'(w_req_ready), 32'd0);
        step(1'b0, 1'b1, 4'h9, 4'h0, 2'b01, 1'b0);
        step(1'b0, 1'b1, 4'h9, 4'h0, 2'b01, 1'b1);
        #2;
        chk("pop_edge_level", 32'(w_level), 32'd3);
        chk("pop_edge_txn",   32'(w_txn_count), 32'd4);
        step(1'b0, 1'b1, 4'h9, 4'h0, 2'b01, 1'b0);
        #2;
        chk("retry_level", 32'(w_level), 32'd4);
        chk("retry_txn",   32'(w_txn_count), 32'd5);
        repeat (5) idle(1'b1);

        // Simultaneous push/pop at level 2, pointers wrap
        do_reset();
        step(1'b0, 1'b1, 4'h3, 4'h5, 2'b10, 1'b0);
        step(1'b0, 1'b1, 4'h6, 4'h5, 2'b10, 1'b0);
        for (int i = 0; i < 9; i++) begin
            step(1'b0, 1'b1, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                 2'($urandom_range(0, 3)), 1'b1);
            #2;
            chk("pp_level", 32'(w_level), 32'd2);
        end
        repeat (3) idle(1'b1);

        // 256 accepts wrap the transaction counter
        do_reset();
        for (int i = 0; i < 256; i++)
            step(1'b0, 1'b1, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                 2'($urandom_range(0, 3)), 1'b1);
        #2;
        chk("txn_wrap", 32'(w_txn_count), 32'd0);
        idle(1'b1);

        // Reset with three entries held
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 4'hF, 4'(i), 2'b00, 1'b0);
        step(1'b1, 1'b1, 4'h1, 4'h1, 2'b00, 1'b0);
        #2;
        r_rst = 1'b0; r_req_valid = 1'b0;
        #1;
        chk("rst_valid", 32'(w_rsp_valid), 32'd0);
        chk("rst_level", 32'(w_level), 32'd0);
        chk("rst_txn",   32'(w_txn_count), 32'd0);
        chk("rst_ready", 32'(w_req_ready), 32'd1);
        chk("rst_data",  32'(w_rsp_data), 32'd0);
        idle(1'b0);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 63) == 0),
                 ($urandom_range(0, 9) < 7),
                 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                 2'($urandom_range(0, 3)),
                 ($urandom_range(0, 9) < 6));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu4_logic_resp.md
ALU4_LOGIC_RESP -- requirements
Module: alu4_logic_resp

Interface
REQ-001 SHALL have parameter WIDTH, default 4, meaning operand and result width in bits.
REQ-002 SHALL have parameter DEPTH, default 4, meaning result FIFO entries; it is a power of two and at least 2.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port req_valid, input, 1 bit: the requester presents an operation.
REQ-006 SHALL have port req_ready, output, 1 bit: the block can accept an operation.
REQ-007 SHALL have port req_a, input, WIDTH bits: operand A.
REQ-008 SHALL have port req_b, input, WIDTH bits: operand B.
REQ-009 SHALL have port req_op, input, 2 bits: 00 AND, 01 OR, 10 XOR, 11 NAND.
REQ-010 SHALL have port rsp_valid, output, 1 bit: the FIFO head holds a result.
REQ-011 SHALL have port rsp_ready, input, 1 bit: the consumer takes the head result.
REQ-012 SHALL have port rsp_data, output, WIDTH bits: head result.
REQ-013 SHALL have port rsp_op, output, 2 bits: opcode that produced the head result.
REQ-014 SHALL have port rsp_zero, output, 1 bit: 1 when rsp_data is all zeros and rsp_valid is 1.
REQ-015 SHALL have port level, output, clog2(DEPTH)+1 bits: current FIFO occupancy.
REQ-016 SHALL have port txn_count, output, 8 bits: number of accepted requests, modulo 256.

Function
REQ-017 A request SHALL be accepted on a rising edge where req_valid=1 and req_ready=1.
REQ-018 req_ready SHALL be 1 exactly when rst=0 and level<DEPTH; it SHALL NOT depend on rsp_ready.
REQ-019 On accept, the bitwise result of req_a/req_b under req_op SHALL be computed over full WIDTH, with no carry or overflow, and written to the FIFO tail together with req_op.
REQ-020 The first rsp_valid for a result SHALL occur in the cycle after its accept edge, giving 1-cycle latency; a write into an empty FIFO SHALL NOT bypass to the outputs in the same cycle.
REQ-021 The FIFO SHALL be first-word-fall-through: rsp_data, rsp_op and rsp_zero SHALL show the head entry combinationally from registered state.
REQ-022 The head SHALL be popped on a rising edge where rsp_valid=1 and rsp_ready=1.
REQ-023 While rsp_valid=1 and rsp_ready=0, rsp_data, rsp_op and rsp_zero SHALL hold stable.
REQ-024 When level=0: rsp_valid=0, rsp_data=0, rsp_op=0, rsp_zero=0; rsp_ready SHALL be ignored.
REQ-025 On an edge with both push and pop, where 0<level<DEPTH, level SHALL stay unchanged and both pointers SHALL advance.
REQ-026 When full, a request SHALL NOT be accepted even if a pop occurs on the same edge; the requester retries next cycle.
REQ-027 Read and write pointers SHALL wrap modulo DEPTH.
REQ-028 txn_count SHALL increment by 1 per accept and wrap from 255 to 0.
REQ-029 Results SHALL leave in the exact order they were accepted.

Reset
REQ-030 While rst=1 at an edge: level, both pointers, and txn_count SHALL become 0, and all stored entries SHALL be discarded.
REQ-031 During a cycle with rst=1, req_ready SHALL be 0, and no request SHALL be accepted on that edge.
REQ-032 Reset mid-operation, with the FIFO non-empty or a handshake pending, SHALL override push and pop; the cycle after rst falls SHALL show rsp_valid=0, level=0, req_ready=1.

Verification
REQ-033 Send a=0000 b=1111 op=00, then a=1110 b=0010 op=00, with rsp_ready=1 -> rsp_data 0000 with rsp_zero=1, then 0010 with rsp_zero=0; each rsp_valid comes one cycle after its accept; txn_count=2.
REQ-034 Send a=1100 b=1010 with ops 01, 10, 11 back-to-back -> rsp_data 1110, 0110, 0111 in order, with rsp_op 01, 10, 11.
REQ-035 Hold rsp_ready=0 and send 5 requests -> level=4, req_ready=0 after the 4th, the 5th is held; then pulse rsp_ready for one cycle -> the 5th is accepted on the following edge, not the pop edge.
REQ-036 With level=2, push and pop on the same edge -> level stays 2; run 9 push/pop cycles so the pointers wrap, and order is preserved.
REQ-037 Accept 256 requests -> txn_count returns to 0.
REQ-038 Assert rst for one cycle with level=3 and rsp_ready=0 -> next cycle rsp_valid=0, level=0, txn_count=0, req_ready=1, rsp_data=0.
